// File: rtl/tfhe_pixel_processor.sv
// ---------------------------------------------------------------------------
// tfhe_pixel_processor
//
// Streams every pixel of the source image through a toy TFHE-style scheme.
// For each pixel it:
//   1. encrypts the pixel,
//   2. encrypts the latched brightness,
//   3. adds the two ciphertexts homomorphically,
//   4. decrypts the sum and writes it into the processed-image frame buffer.
//
// Ciphertext layout is {a[11:0], b[7:0]}, with b = m + (a*s mod 256).
// Each pixel takes four cycles: READ, ENC, ADD and WRITE.
//
// Ports:
//   clk, rst    system clock; asynchronous active-high reset
//   start       one-cycle frame request, honoured only while idle
//   brightness  plaintext addend, captured when start is accepted
//   rd_addr     image ROM address (synchronous ROM, one cycle latency)
//   rd_data     image ROM data
//   wr_en       frame-buffer write strobe, one cycle per pixel
//   wr_addr     frame-buffer write address
//   wr_data     frame-buffer write data (decrypted result)
//   busy        a frame is in progress
//   done        the whole frame has been written (sticky until next start)
//   ct_sum      most recent homomorphic sum, for debug visibility
// ---------------------------------------------------------------------------
module tfhe_pixel_processor #(
    parameter int          NUM_PIXELS = 4096,
    parameter int          ADDR_W     = 12,
    parameter logic [7:0]  SECRET_KEY = 8'hA5,
    parameter logic [11:0] LFSR_SEED  = 12'hACE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        brightness,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic [19:0]       ct_sum
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [11:0]       SEED_EFF  = (LFSR_SEED == 12'h000) ? 12'h001 : LFSR_SEED;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        ENC,
        ADD,
        WRITE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       lfsr_q, lfsr_d;
    logic [7:0]        br_q, br_d;
    logic [19:0]       ct1_q, ct1_d;
    logic [19:0]       ct2_q, ct2_d;
    logic [19:0]       ct_sum_q, ct_sum_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              done_q, done_d;

    // Combinational results of the per-pixel arithmetic.
    logic [11:0]       lfsr_next1;
    logic [19:0]       sum_ct;

    // 12-bit Fibonacci LFSR step, shifting left.
    function automatic logic [11:0] lfsr_step(input logic [11:0] q);
        return {q[10:0], q[11] ^ q[10] ^ q[9] ^ q[3]};
    endfunction

    // (a*s) mod 256 depends only on a[7:0], so an 8x8 product truncated
    // to 8 bits is enough.
    function automatic logic [7:0] key_mask(input logic [11:0] a);
        logic [7:0] r;
        r = a[7:0] * SECRET_KEY;
        return r;
    endfunction

    function automatic logic [19:0] encrypt(input logic [7:0] m, input logic [11:0] a);
        return {a, m + key_mask(a)};
    endfunction

    function automatic logic [19:0] ct_add(input logic [19:0] c1, input logic [19:0] c2);
        return {c1[19:8] + c2[19:8], c1[7:0] + c2[7:0]};
    endfunction

    // Because 256 divides 4096, the wrap of the a field does not disturb
    // the mask, so this recovers (pixel + brightness) mod 256 exactly.
    function automatic logic [7:0] decrypt(input logic [19:0] c);
        return c[7:0] - key_mask(c[19:8]);
    endfunction

    assign lfsr_next1 = lfsr_step(lfsr_q);
    assign sum_ct     = ct_add(ct1_q, ct2_q);

    // State register and datapath registers. Reset restores the seed so a
    // restarted frame reproduces the same ciphertext masks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            lfsr_q    <= SEED_EFF;
            br_q      <= '0;
            ct1_q     <= '0;
            ct2_q     <= '0;
            ct_sum_q  <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lfsr_q    <= lfsr_d;
            br_q      <= br_d;
            ct1_q     <= ct1_d;
            ct2_q     <= ct2_d;
            ct_sum_q  <= ct_sum_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath updates.
    // rd_addr is loaded on the edge that enters READ so the synchronous ROM
    // samples it at the end of READ and its data is valid during ENC.
    // wr_addr/wr_data are loaded on the edge that enters WRITE, so they are
    // valid while wr_en is high and then hold until the next pixel.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        lfsr_d    = lfsr_q;
        br_d      = br_q;
        ct1_d     = ct1_q;
        ct2_d     = ct2_q;
        ct_sum_d  = ct_sum_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    br_d      = brightness;
                    addr_d    = '0;
                    rd_addr_d = '0;
                    done_d    = 1'b0;
                    state_d   = READ;
                end
            end
            READ: begin
                state_d = ENC;
            end
            ENC: begin
                ct1_d   = encrypt(rd_data, lfsr_q);
                ct2_d   = encrypt(br_q, lfsr_next1);
                lfsr_d  = lfsr_step(lfsr_next1);
                state_d = ADD;
            end
            ADD: begin
                ct_sum_d  = sum_ct;
                wr_addr_d = addr_q;
                wr_data_d = decrypt(sum_ct);
                state_d   = WRITE;
            end
            WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    addr_d    = addr_q + ADDR_ONE;
                    rd_addr_d = addr_q + ADDR_ONE;
                    state_d   = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register so that reset drops
    // them immediately.
    assign wr_en   = (state_q == WRITE);
    assign busy    = (state_q != IDLE);
    assign rd_addr = rd_addr_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;
    assign ct_sum  = ct_sum_q;

endmodule

// File: tb/tb_tfhe_pixel_processor.sv
// ---------------------------------------------------------------------------
// tb_tfhe_pixel_processor
//
// Directed bench for tfhe_pixel_processor. A 4-pixel instance covers the
// cycle-level scenarios; a default 4096-pixel instance covers a full frame.
// Cycle index c counts posedges since the edge that accepted start, and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_tfhe_pixel_processor;

    logic clk;
    logic rst;

    // Small 4-pixel instance
    logic        start_s;
    logic [7:0]  brightness_s;
    logic [11:0] rd_addr_s;
    logic [7:0]  rd_data_s;
    logic        wr_en_s;
    logic [11:0] wr_addr_s;
    logic [7:0]  wr_data_s;
    logic        busy_s;
    logic        done_s;
    logic [19:0] ct_sum_s;

    // Full-frame instance
    logic        start_f;
    logic [7:0]  brightness_f;
    logic [11:0] rd_addr_f;
    logic [7:0]  rd_data_f;
    logic        wr_en_f;
    logic [11:0] wr_addr_f;
    logic [7:0]  wr_data_f;
    logic        busy_f;
    logic        done_f;
    logic [19:0] ct_sum_f;

    logic [7:0] rom_s [4];
    logic [7:0] rom_f [4096];

    int vectors;
    int miscompares;

    // Writes captured from the small instance
    logic [11:0] cap_addr [$];
    logic [7:0]  cap_data [$];
    logic [19:0] cap_ct   [$];
    int          cap_cyc  [$];

    logic [7:0] exp_d [4];

    tfhe_pixel_processor #(
        .NUM_PIXELS(4),
        .ADDR_W    (12)
    ) dut_small (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .brightness(brightness_s),
        .rd_addr   (rd_addr_s),
        .rd_data   (rd_data_s),
        .wr_en     (wr_en_s),
        .wr_addr   (wr_addr_s),
        .wr_data   (wr_data_s),
        .busy      (busy_s),
        .done      (done_s),
        .ct_sum    (ct_sum_s)
    );

    tfhe_pixel_processor dut_full (
        .clk       (clk),
        .rst       (rst),
        .start     (start_f),
        .brightness(brightness_f),
        .rd_addr   (rd_addr_f),
        .rd_data   (rd_data_f),
        .wr_en     (wr_en_f),
        .wr_addr   (wr_addr_f),
        .wr_data   (wr_data_f),
        .busy      (busy_f),
        .done      (done_f),
        .ct_sum    (ct_sum_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM models
    always @(posedge clk) begin
        rd_data_s <= rom_s[rd_addr_s[1:0]];
        rd_data_f <= rom_f[rd_addr_f];
    end

    task automatic clear_cap();
        cap_addr.delete();
        cap_data.delete();
        cap_ct.delete();
        cap_cyc.delete();
    endtask

    task automatic sample_small(input int c);
        if (wr_en_s === 1'b1) begin
            cap_addr.push_back(wr_addr_s);
            cap_data.push_back(wr_data_s);
            cap_ct.push_back(ct_sum_s);
            cap_cyc.push_back(c);
        end
    endtask

    // Returns at the falling edge of cycle c=1 (start accepted one edge earlier)
    task automatic pulse_start_small(input logic [7:0] br);
        @(negedge clk);
        brightness_s = br;
        start_s      = 1'b1;
        @(negedge clk);
        start_s      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_basic_rom();
        rom_s[0] = 8'h10;
        rom_s[1] = 8'h00;
        rom_s[2] = 8'h7F;
        rom_s[3] = 8'hF8;
        exp_d[0] = 8'h1F;
        exp_d[1] = 8'h0F;
        exp_d[2] = 8'h8E;
        exp_d[3] = 8'h07;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        vectors++;
        if (rd_addr_s !== 12'h000) begin miscompares++; $display("[TB] FAIL reset_rd_addr: got %h, expected 000", rd_addr_s); end
        vectors++;
        if (wr_en_s !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wr_en: got %b, expected 0", wr_en_s); end
        vectors++;
        if (wr_addr_s !== 12'h000) begin miscompares++; $display("[TB] FAIL reset_wr_addr: got %h, expected 000", wr_addr_s); end
        vectors++;
        if (wr_data_s !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_wr_data: got %h, expected 00", wr_data_s); end
        vectors++;
        if (busy_s !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy_s); end
        vectors++;
        if (done_s !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b, expected 0", done_s); end
        vectors++;
        if (ct_sum_s !== 20'h00000) begin miscompares++; $display("[TB] FAIL reset_ct_sum: got %h, expected 00000", ct_sum_s); end
        vectors++;
        if (busy_f !== 1'b0 || done_f !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full_status: got busy=%b done=%b, expected 0 0", busy_f, done_f); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy_s !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_after_release: got busy=%b, expected 0", busy_s); end
    endtask

    // ROM {10,00,7F,F8}, brightness 0F: writes, cycles, done timing, first ct_sum.
    task automatic test_basic();
        do_reset();
        load_basic_rom();
        clear_cap();
        pulse_start_small(8'h0F);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            sample_small(c);
            if (c == 1) begin
                vectors++;
                if (busy_s !== 1'b1 || done_s !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_busy_c1: got busy=%b done=%b, expected 1 0", busy_s, done_s); end
            end
            if (c == 16) begin
                vectors++;
                if (done_s !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_done_c16: got %b, expected 0", done_s); end
            end
            if (c == 17) begin
                vectors++;
                if (done_s !== 1'b1 || busy_s !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_done_c17: got done=%b busy=%b, expected 1 0", done_s, busy_s); end
            end
        end
        vectors++;
        if (cap_data.size() != 4) begin miscompares++; $display("[TB] FAIL basic_write_count: got %0d, expected 4", cap_data.size()); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= cap_data.size() || cap_addr[i] !== 12'(i) || cap_data[i] !== exp_d[i] || cap_cyc[i] != 4 * i + 4) begin
                miscompares++;
                if (i < cap_data.size())
                    $display("[TB] FAIL basic_write%0d: got addr=%h data=%h cycle=%0d, expected addr=%h data=%h cycle=%0d", i, cap_addr[i], cap_data[i], cap_cyc[i], 12'(i), exp_d[i], 4 * i + 4);
                else
                    $display("[TB] FAIL basic_write%0d: got no write, expected data=%h", i, exp_d[i]);
            end
        end
        // a = ACE+59D = 06B (mod 4096); mask(06B) = F7; b = 10+0F+F7 = 16
        vectors++;
        if (cap_ct.size() < 1 || cap_ct[0] !== 20'h06B16) begin miscompares++; $display("[TB] FAIL basic_ct_sum0: got %h, expected 06B16", (cap_ct.size() > 0) ? cap_ct[0] : 20'hxxxxx); end
    endtask

    // FF+01 wraps to 00; then 80+FF wraps to 7F with a later LFSR position.
    task automatic test_wraparound();
        do_reset();
        rom_s[0] = 8'hFF; rom_s[1] = 8'h00; rom_s[2] = 8'h00; rom_s[3] = 8'h00;
        clear_cap();
        pulse_start_small(8'h01);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            sample_small(c);
        end
        vectors++;
        if (cap_data.size() < 1 || cap_data[0] !== 8'h00) begin miscompares++; $display("[TB] FAIL wrap_ff_plus_01: got %h, expected 00", (cap_data.size() > 0) ? cap_data[0] : 8'hxx); end
        vectors++;
        if (cap_ct.size() < 1 || cap_ct[0] !== 20'h06BF7) begin miscompares++; $display("[TB] FAIL wrap_ct_sum_a: got %h, expected 06BF7", (cap_ct.size() > 0) ? cap_ct[0] : 20'hxxxxx); end

        // LFSR has advanced 8 steps: a1 = EAC, a2 = D58, a = C04, mask = 94
        rom_s[0] = 8'h80;
        clear_cap();
        pulse_start_small(8'hFF);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            sample_small(c);
        end
        vectors++;
        if (cap_data.size() < 1 || cap_data[0] !== 8'h7F) begin miscompares++; $display("[TB] FAIL wrap_80_plus_ff: got %h, expected 7F", (cap_data.size() > 0) ? cap_data[0] : 8'hxx); end
        vectors++;
        if (cap_ct.size() < 1 || cap_ct[0] !== 20'hC0413) begin miscompares++; $display("[TB] FAIL wrap_ct_sum_b: got %h, expected C0413", (cap_ct.size() > 0) ? cap_ct[0] : 20'hxxxxx); end
    endtask

    // Brightness changes mid-frame must not reach the running frame.
    task automatic test_latching();
        for (int i = 0; i < 4; i++) rom_s[i] = 8'h05;
        clear_cap();
        pulse_start_small(8'h20);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            sample_small(c);
            if (c == 6) brightness_s = 8'h00;
        end
        vectors++;
        if (cap_data.size() != 4) begin miscompares++; $display("[TB] FAIL latch_write_count: got %0d, expected 4", cap_data.size()); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= cap_data.size() || cap_data[i] !== 8'h25) begin miscompares++; $display("[TB] FAIL latch_write%0d: got %h, expected 25", i, (i < cap_data.size()) ? cap_data[i] : 8'hxx); end
        end
    endtask

    // Extra start pulses while busy are ignored; a later start repeats the frame.
    task automatic test_start_while_busy();
        do_reset();
        load_basic_rom();
        clear_cap();
        pulse_start_small(8'h0F);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            sample_small(c);
            if (c == 16) begin
                vectors++;
                if (done_s !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_start_done_c16: got %b, expected 0", done_s); end
            end
            if (c == 17) begin
                vectors++;
                if (done_s !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_start_done_c17: got %b, expected 1", done_s); end
            end
            start_s = (c == 3 || c == 9);
        end
        start_s = 1'b0;
        vectors++;
        if (cap_data.size() != 4) begin miscompares++; $display("[TB] FAIL busy_start_write_count: got %0d, expected 4", cap_data.size()); end

        clear_cap();
        pulse_start_small(8'h0F);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            sample_small(c);
            if (c == 1) begin
                vectors++;
                if (done_s !== 1'b0) begin miscompares++; $display("[TB] FAIL second_frame_done_cleared: got %b, expected 0", done_s); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= cap_data.size() || cap_data[i] !== exp_d[i] || cap_addr[i] !== 12'(i)) begin miscompares++; $display("[TB] FAIL second_frame_write%0d: got %h, expected %h", i, (i < cap_data.size()) ? cap_data[i] : 8'hxx, exp_d[i]); end
        end
        // a = EAC+D58 = C04, mask = 94, b = 10+0F+94 = B3
        vectors++;
        if (cap_ct.size() < 1 || cap_ct[0] !== 20'hC04B3) begin miscompares++; $display("[TB] FAIL second_frame_ct_sum0: got %h, expected C04B3", (cap_ct.size() > 0) ? cap_ct[0] : 20'hxxxxx); end
    endtask

    // Reset at cycle 7 aborts the frame; the next frame reproduces the first.
    task automatic test_reset_midframe();
        do_reset();
        load_basic_rom();
        clear_cap();
        pulse_start_small(8'h0F);
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge clk);
            sample_small(c);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (rd_addr_s !== 12'h000 || wr_en_s !== 1'b0 || wr_addr_s !== 12'h000 || wr_data_s !== 8'h00)
        begin miscompares++; $display("[TB] FAIL midreset_outputs: got rd_addr=%h wr_en=%b wr_addr=%h wr_data=%h, expected 000 0 000 00", rd_addr_s, wr_en_s, wr_addr_s, wr_data_s); end
        vectors++;
        if (busy_s !== 1'b0 || done_s !== 1'b0 || ct_sum_s !== 20'h00000)
        begin miscompares++; $display("[TB] FAIL midreset_status: got busy=%b done=%b ct_sum=%h, expected 0 0 00000", busy_s, done_s, ct_sum_s); end
        vectors++;
        if (cap_data.size() != 1) begin miscompares++; $display("[TB] FAIL midreset_writes_before: got %0d, expected 1", cap_data.size()); end
        for (int c = 8; c <= 20; c++) begin
            @(negedge clk);
            sample_small(c);
            if (c == 10) rst = 1'b0;
        end
        vectors++;
        if (cap_data.size() != 1 || done_s !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_no_writes_after: got writes=%0d done=%b, expected 1 0", cap_data.size(), done_s); end

        clear_cap();
        pulse_start_small(8'h0F);
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            sample_small(c);
        end
        vectors++;
        if (cap_data.size() < 1 || cap_addr[0] !== 12'h000 || cap_data[0] !== 8'h1F || cap_ct[0] !== 20'h06B16)
        begin miscompares++; $display("[TB] FAIL midreset_restart: got addr=%h data=%h ct=%h, expected 000 1F 06B16", (cap_addr.size() > 0) ? cap_addr[0] : 12'hxxx, (cap_data.size() > 0) ? cap_data[0] : 8'hxx, (cap_ct.size() > 0) ? cap_ct[0] : 20'hxxxxx); end
        for (int c = 7; c <= 20; c++) @(negedge clk);
    endtask

    // Default 4096-pixel frame.
    task automatic test_full_frame();
        int         nwr;
        logic [7:0] expv;
        nwr = 0;
        @(negedge clk);
        brightness_f = 8'h0F;
        start_f      = 1'b1;
        @(negedge clk);
        start_f      = 1'b0;
        for (int c = 1; c <= 16390; c++) begin
            if (c > 1) @(negedge clk);
            if (wr_en_f === 1'b1) begin
                expv = (nwr < 4096) ? rom_f[nwr] + 8'h0F : 8'hxx;
                vectors++;
                if (nwr >= 4096 || wr_addr_f !== 12'(nwr) || wr_data_f !== expv || c != 4 * nwr + 4) begin
                    miscompares++;
                    $display("[TB] FAIL full_write%0d: got addr=%h data=%h cycle=%0d, expected addr=%h data=%h cycle=%0d", nwr, wr_addr_f, wr_data_f, c, 12'(nwr), expv, 4 * nwr + 4);
                end
                nwr++;
            end
            if (c == 16384) begin
                vectors++;
                if (done_f !== 1'b0) begin miscompares++; $display("[TB] FAIL full_done_c16384: got %b, expected 0", done_f); end
            end
            if (c == 16385) begin
                vectors++;
                if (done_f !== 1'b1 || busy_f !== 1'b0) begin miscompares++; $display("[TB] FAIL full_done_c16385: got done=%b busy=%b, expected 1 0", done_f, busy_f); end
            end
        end
        vectors++;
        if (nwr != 4096) begin miscompares++; $display("[TB] FAIL full_write_count: got %0d, expected 4096", nwr); end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        start_s      = 1'b0;
        brightness_s = 8'h00;
        start_f      = 1'b0;
        brightness_f = 8'h00;
        for (int i = 0; i < 4; i++) rom_s[i] = 8'h00;
        for (int i = 0; i < 4096; i++) rom_f[i] = 8'((i * 37) + (i >> 5));

        test_reset();
        test_basic();
        test_wraparound();
        test_latching();
        test_start_while_busy();
        test_reset_midframe();
        test_full_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
